// File: rtl/fft_out_serializer_pkg.sv
// Shared types and helpers for the FFT output serializer.
// Optional build macro: FFT_OUT_BITREV_EN (bins arrive in bit-reversed order).
package fft_out_serializer_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned FFT_N      = 8;
  localparam int unsigned DROP_CNT_W = 8;

  // One complex FFT bin as produced by the FFT core.
  typedef struct packed {
    logic signed [DATA_W-1:0] r;
    logic signed [DATA_W-1:0] i;
  } complex_product_t;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  // Reverse the low 'width' bits of x; upper result bits are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] x, input int unsigned width);
    logic [31:0] y;
    logic [31:0] t;
    y = '0;
    t = x;
    for (int unsigned b = 0; b < width; b++) begin
      y = {y[30:0], t[0]};
      t = t >> 1;
    end
    return y;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One N-entry frame register bank: whole-frame capture, combinational read.
module fft_frame_bank
  import fft_out_serializer_pkg::*;
#(
  parameter int unsigned N = FFT_N,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cap_en,
  input  complex_product_t wr_frame [N],
  input  logic [IDX_W-1:0] rd_addr,
  output complex_product_t rd_data
);

  complex_product_t mem_q [N];
  complex_product_t mem_d [N];

  // Next contents: load the whole frame on capture, otherwise hold.
  always_comb begin
    mem_d = mem_q;
    if (cap_en) begin
      mem_d = wr_frame;
    end
  end

  // Frame storage; cleared on reset so a discarded frame never leaks out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(N); k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fft_out_serializer.sv
// Ping-pong capture of FFT output frames, streamed one bin per cycle.
// Optional build macro: FFT_OUT_BITREV_EN (read bins through a bit-reversed address).
module fft_out_serializer
  import fft_out_serializer_pkg::*;
#(
  parameter int unsigned N     = FFT_N,
  parameter int unsigned CNT_W = DROP_CNT_W,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  complex_product_t in_frame [N],
  input  logic             in_valid,
  output complex_product_t out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] drop_count,
  output logic             busy
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  bank_state_e      flag_q [2];
  bank_state_e      flag_d [2];
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  logic [1:0]       cap_en;
  logic [IDX_W-1:0] rd_addr;
  complex_product_t rd_data [2];
  logic             xfer;
  logic             rel_bank;
  logic             wr_free;

  // Map the natural-order output index to the storage address.
`ifdef FFT_OUT_BITREV_EN
  assign rd_addr = IDX_W'(bitrev(32'(rd_idx_q), IDX_W));
`else
  assign rd_addr = rd_idx_q;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank #(.N(N)) u_bank (
      .clk      (clk),
      .reset    (reset),
      .cap_en   (cap_en[b]),
      .wr_frame (in_frame),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data[b])
    );
  end

  assign out_valid  = (flag_q[rd_bank_q] == BANK_FULL);
  assign out_data   = rd_data[rd_bank_q];
  assign out_index  = rd_idx_q;
  assign out_last   = out_valid && (rd_idx_q == IDX_LAST);
  assign busy       = (flag_q[0] == BANK_FULL) || (flag_q[1] == BANK_FULL);
  assign drop_count = drop_count_q;

  assign xfer     = out_valid && out_ready;
  assign rel_bank = xfer && (rd_idx_q == IDX_LAST);
  // A bank released by the final transfer this cycle can take the new frame.
  assign wr_free  = (flag_q[wr_bank_q] == BANK_EMPTY) || (rel_bank && (rd_bank_q == wr_bank_q));

  // Read advance first, then capture, so a same-cycle release is refilled.
  always_comb begin
    flag_d       = flag_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    rd_idx_d     = rd_idx_q;
    drop_count_d = drop_count_q;
    cap_en       = '0;

    if (xfer) begin
      rd_idx_d = rd_idx_q + 1'b1;
      if (rel_bank) begin
        flag_d[rd_bank_q] = BANK_EMPTY;
        rd_bank_d         = ~rd_bank_q;
      end
    end

    if (in_valid) begin
      if (wr_free) begin
        cap_en[wr_bank_q] = 1'b1;
        flag_d[wr_bank_q] = BANK_FULL;
        wr_bank_d         = ~wr_bank_q;
      end else if (drop_count_q != CNT_MAX) begin
        drop_count_d = drop_count_q + 1'b1;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_q[0]    <= BANK_EMPTY;
      flag_q[1]    <= BANK_EMPTY;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      rd_idx_q     <= '0;
      drop_count_q <= '0;
    end else begin
      flag_q       <= flag_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      rd_idx_q     <= rd_idx_d;
      drop_count_q <= drop_count_d;
    end
  end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Scoreboard bench for fft_out_serializer (honours FFT_OUT_BITREV_EN).
module tb_fft_out_serializer;
  import fft_out_serializer_pkg::*;

  localparam int unsigned N     = 8;
  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    complex_product_t d;
    logic [2:0]       idx;
    logic             last;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  complex_product_t in_frame [N];
  logic             in_valid;
  complex_product_t out_data;
  logic [2:0]       out_index;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [CNT_W-1:0] drop_count;
  logic             busy;

  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   src_tab [N];

  fft_out_serializer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_frame   (in_frame),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame 'tag': entry k has r = k*256 + tag, i = tag*16 - k.
  task automatic load_frame(input int tag);
    for (int k = 0; k < int'(N); k++) begin
      in_frame[k].r = 16'(k * 256 + tag);
      in_frame[k].i = 16'(tag * 16 - k);
    end
  endtask

  task automatic push_exp(input int tag);
    exp_t e;
    for (int j = 0; j < int'(N); j++) begin
      e.d.r  = 16'(src_tab[j] * 256 + tag);
      e.d.i  = 16'(tag * 16 - src_tab[j]);
      e.idx  = 3'(j);
      e.last = (j == int'(N) - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse(input int tag);
    load_frame(tag);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (busy || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain timeout busy=%0b pending=%0d required busy=0 pending=0",
               name, busy, exp_q.size());
    end
  endtask

  // Monitor: every accepted bin must match the oldest expected bin.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer actual index=%0d data=%0h required no transfer",
                 out_index, out_data);
      end else begin
        e = exp_q.pop_front();
        check("xfer_data",  64'(out_data),  64'(e.d));
        check("xfer_index", 64'(out_index), 64'(e.idx));
        check("xfer_last",  64'(out_last),  64'(e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    int bad;
    complex_product_t a0;

`ifdef FFT_OUT_BITREV_EN
    src_tab = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    src_tab = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    load_frame(0);
    tick();
    tick();
    check("rst_out_valid",  64'(out_valid),  64'(0));
    check("rst_out_last",   64'(out_last),   64'(0));
    check("rst_busy",       64'(busy),       64'(0));
    check("rst_out_data",   64'(out_data),   64'(0));
    check("rst_out_index",  64'(out_index),  64'(0));
    check("rst_drop_count", 64'(drop_count), 64'(0));
    reset = 1'b0;
    tick();

    // Single frame, ready held high.
    out_ready = 1'b1;
    push_exp(0);
    pulse(0);
    check("lat_valid", 64'(out_valid), 64'(1));
    check("lat_index", 64'(out_index), 64'(0));
    repeat (7) tick();
    check("busy_before_last", 64'(busy), 64'(1));
    tick();
    check("busy_after_last", 64'(busy), 64'(0));

    // Back-to-back frames 8 cycles apart stream with no gap.
    push_exp(1);
    push_exp(2);
    load_frame(1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    nv = 0;
    for (int i = 0; i < 16; i++) begin
      if (out_valid) nv++;
      if (i == 7) begin
        load_frame(2);
        in_valid = 1'b1;
      end
      tick();
      in_valid = 1'b0;
    end
    check("b2b_valid_cycles", 64'(nv), 64'(16));
    check("b2b_drop_count", 64'(drop_count), 64'(0));
    check("b2b_busy_end", 64'(busy), 64'(0));

    // Backpressure: three frames, third one dropped, output held on A bin 0.
    out_ready = 1'b0;
    push_exp(3);
    push_exp(4);
    a0.r = 16'(3);
    a0.i = 16'(48);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 0) begin load_frame(3); in_valid = 1'b1; end
      else if (c == 8) begin load_frame(4); in_valid = 1'b1; end
      else if (c == 16) begin load_frame(5); in_valid = 1'b1; end
      else in_valid = 1'b0;
      tick();
      if (out_valid !== 1'b1 || out_data !== a0 || out_index !== 3'd0 || out_last !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    check("bp_hold_cycles_bad", 64'(bad), 64'(0));
    check("bp_drop_count", 64'(drop_count), 64'(1));
    check("bp_busy", 64'(busy), 64'(1));
    out_ready = 1'b1;
    wait_idle("bp_drain", 40);

    // Final bin of the oldest bank leaves as a new frame arrives: accepted.
    out_ready = 1'b0;
    push_exp(6);
    push_exp(7);
    push_exp(8);
    pulse(6);
    pulse(7);
    out_ready = 1'b1;
    repeat (7) tick();
    check("rel_cap_align", 64'(out_index), 64'(7));
    load_frame(8);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rel_cap_drop_now", 64'(drop_count), 64'(1));
    wait_idle("rel_cap_drain", 40);
    check("rel_cap_drop_end", 64'(drop_count), 64'(1));

    // Asynchronous reset in the middle of a frame.
    push_exp(9);
    pulse(9);
    repeat (3) tick();
    check("mid_rst_idx_before", 64'(out_index), 64'(3));
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_drop", 64'(drop_count), 64'(0));
    check("mid_rst_index", 64'(out_index), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    push_exp(10);
    pulse(10);
    check("post_rst_valid", 64'(out_valid), 64'(1));
    check("post_rst_index", 64'(out_index), 64'(0));
    wait_idle("post_rst_drain", 40);

    // Drop counter saturation.
    out_ready = 1'b0;
    pulse(11);
    pulse(12);
    load_frame(13);
    in_valid = 1'b1;
    repeat (100) tick();
    check("sat_drop_100", 64'(drop_count), 64'(100));
    repeat (159) tick();
    in_valid = 1'b0;
    check("sat_drop_max", 64'(drop_count), 64'(255));
    push_exp(11);
    push_exp(12);
    out_ready = 1'b1;
    wait_idle("sat_drain", 40);
    check("sat_drop_hold", 64'(drop_count), 64'(255));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_out_serializer.md
Name: fft_out_serializer

Overview:
- Sits directly downstream of the 8-point radix-2 FFT core (fft_8_rad2).
- Captures the parallel fft_out vector whenever the core pulses out_valid, then streams bins one per cycle on a valid/ready interface to the subcarrier demapper.
- Holds two frame banks (ping-pong), so the core never stalls; a frame that arrives with no free bank is dropped and counted.

Parameters:
- N, 8, FFT size; power of two, at least 2.
- CNT_W, 8, width of the dropped-frame counter.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- in_frame  in  N x complex_product_t  fft_out vector from the FFT core.
- in_valid  in  1  single-cycle capture strobe (the core's out_valid).
- out_data  out  complex_product_t  current bin.
- out_index  out  $clog2(N)  natural-order bin number of out_data.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_last  out  1  high with the bin where out_index == N-1.
- drop_count  out  CNT_W  saturating count of dropped frames.
- busy  out  1  at least one bank is full.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - Both banks EMPTY; wr_bank = 0, rd_bank = 0, rd_idx = 0, drop_count = 0.
  - out_valid = 0, out_last = 0, busy = 0, out_data = 0, out_index = 0.
- State: each bank has a 1-bit flag, EMPTY or FULL.
  - wr_bank is the next bank to fill; rd_bank is the oldest full bank.
  - Both toggle modulo 2.
- Capture: when in_valid=1 and bank[wr_bank] is EMPTY (or is freed this same cycle, see below):
  - All N entries are registered into bank[wr_bank] at the clock edge.
  - bank[wr_bank] is set FULL and wr_bank toggles.
- Drop: when in_valid=1 and no bank is free:
  - The frame is discarded and the bank contents are unchanged.
  - drop_count increments and saturates at 2^CNT_W-1.
- Latency: in_valid at cycle t gives out_valid=1 at cycle t+1 with out_index=0, provided the read side was idle.
- Output path:
  - out_valid = bank[rd_bank] is FULL.
  - out_data is read combinationally from the registered bank at address src(rd_idx).
  - out_index = rd_idx; out_last = out_valid && rd_idx == N-1.
- Handshake:
  - A transfer occurs when out_valid && out_ready.
  - out_data, out_index and out_last hold stable while out_valid && !out_ready.
  - out_ready has no effect while out_valid=0.
- Index advance:
  - On a transfer, rd_idx increments.
  - On a transfer with rd_idx == N-1: rd_idx wraps to 0, bank[rd_bank] becomes EMPTY and rd_bank toggles.
  - Back-to-back frames stream with no idle cycle.
- Simultaneous events:
  - Same-cycle release and capture: if both banks are FULL and the final bin of bank[rd_bank] transfers in the same cycle as in_valid, the capture succeeds into the freed bank (here wr_bank == rd_bank). That bank ends FULL and no drop is counted.
  - Capture and read on different banks in the same cycle proceed independently.
- Reset mid-frame: every in-flight bank is discarded and the state returns to the reset values above.
- Arithmetic: no arithmetic on the data; samples pass bit-exact. drop_count is the only counter that saturates.

Optional Feature:
- Macro: FFT_OUT_BITREV_EN.
- Defined:
  - The FFT core's in_frame[k] holds bin bitrev(k) over $clog2(N) bits.
  - src(rd_idx) = bitrev(rd_idx), so bins leave in natural order (for N=8, read addresses are 0,4,2,6,1,5,3,7).
- Not defined: src(rd_idx) = rd_idx, and bins leave in in_frame index order.
- out_index always equals rd_idx.

Decomposition:
- complex_product_t stays in headers.svh.
- Add a shared bitrev function (parameterised by width) in the same package so the bench can reuse it.
- One natural sub-module: fft_frame_bank, a single N-entry register bank with capture enable and combinational read port, instantiated twice.
- Control (flags, pointers, rd_idx, drop counter) lives in the top level.

Test Plan:
- Single frame, out_ready=1:
  - Stimulus: in_frame[k].r=k*256, .i=-k, one in_valid pulse.
  - Response: 8 consecutive transfers starting at t+1, out_last only on the 8th, busy falls after the last transfer.
  - With FFT_OUT_BITREV_EN defined, out_data.r sequence is 0,1024,512,1536,256,1280,768,1792.
- Back-to-back frames A and B, in_valid 8 cycles apart, out_ready=1: 16 contiguous transfers with no gap and drop_count=0.
- Backpressure:
  - Stimulus: out_ready=0 for 20 cycles, frames A, B, C at cycles 0, 8, 16.
  - Response: C dropped, drop_count=1, out_data stays equal to A bin 0 throughout.
  - Releasing out_ready then yields all of A followed by all of B.
- Same-cycle release and capture: both banks FULL, frame D's in_valid coincides with the final transfer of A -> D accepted, drop_count unchanged, D streams after B.
- Reset asserted mid-stream at rd_idx=3 -> out_valid=0 immediately (asynchronous), drop_count=0. A new frame after deassertion streams from index 0.
- Counter saturation: 2^CNT_W+3 forced drops -> drop_count holds at 255 (CNT_W=8).
